spi_flash_responder: RTL and testbench
======================================

# spi_flash_responder

Synthesizable SPI NOR-flash responder: the slave end of the controller's SPI link, replacing the behavioural flash model on the bench and usable as an FPGA flash stand-in. It oversamples `s_clk`/`s_css`/`s_mosi` in the `p_clk` domain and decodes 32-bit command words. It executes READ, PROGRAM, WREN, WRDI and RDSR against an internal word array, driving `s_miso`. Word framing matches the controller: one 32-bit word per `s_clk` rising edge, with `s_css` active low.

## Interface
- `LINEWIDE`, 32: SPI word width; fixed at 32.
- `DEPTH`, 256: memory depth in words; power of two.
- `BUSY_CYCLES`, 16: `p_clk` cycles WIP stays set after a PROGRAM frame; ≥1.
- `p_clk` input 1: single clock; all logic rises on it.
- `p_resetn` input 1: reset, synchronous, active-low.
- `s_clk` input 1: SPI clock from the controller; asynchronous to `p_clk`.
- `s_css` input 1: chip select, active low.
- `s_mosi` input 32: word from the controller; stable around `s_clk` rising edge.
- `s_miso` output 32: response word.
- `wip` output 1: status bit 0, write in progress.
- `wel` output 1: status bit 1, write-enable latch.

## Operation
- **Synchronization.** `s_clk`, `s_css` and `s_mosi` each pass through two flops. Edges are detected on the synchronized copies.
  - `sck_rise`: synchronized `s_clk` was 0 and is now 1.
  - `sck_fall`: synchronized `s_clk` was 1 and is now 0.
  - `css_fall`, `css_rise`: the same edge detection on `s_css`.
- **Frame start.** `css_fall` enters state CMD. A `sck_rise` while CMD captures word 0 as `cmd = mosi[7:0]` and `addr = mosi[31:8]`. The word index is `addr[log2(DEPTH)-1:0]`; the upper address bits are ignored.
- **States:** IDLE, CMD, READ, PROG, RDSR, IGNORE. Any `css_rise` returns to IDLE from every state.
- **Decode at the word-0 `sck_rise`:**
  - If `wip`=1: `cmd` 0x05 goes to RDSR; every other `cmd` goes to IGNORE.
  - 0x01 goes to READ.
  - 0x02 goes to PROG if `wel`=1, else to IGNORE.
  - 0x06 sets `wel` and goes to IGNORE.
  - 0x04 clears `wel` and goes to IGNORE.
  - 0x05 goes to RDSR.
  - Any other `cmd` goes to IGNORE.
- **READ.** Each `sck_fall` drives `s_miso = mem[idx]`, then increments `idx`. Each `sck_rise` does nothing. `idx` wraps from `DEPTH-1` to 0.
- **PROG.** Each `sck_rise` writes `mem[idx] = mosi`, then increments `idx` with wrap, and sets the `wrote` flag. On `css_rise` with `wrote`=1: set `wip`, load the busy counter with `BUSY_CYCLES`, clear `wrote`. A PROG frame aborted before any data word writes nothing and leaves `wel`=1.
- **Busy.** While `wip`=1 the counter decrements once per `p_clk`. When it reaches 0, `wip` and `wel` are both cleared in the same cycle.
- **RDSR.** Each `sck_fall` drives `s_miso = {30'b0, wel, wip}`.
- **IDLE/IGNORE.** `s_miso` holds its last value and memory is untouched.
- **Reset.** With `p_resetn`=0 at a `p_clk` edge:
  - state returns to IDLE;
  - `s_miso`, `wip`, `wel`, `wrote`, the busy counter and all sync flops go to 0;
  - memory contents are preserved, not reset.
  
  Reset mid-frame drops the frame. The responder resynchronizes on the next `css_fall`.
- **Simultaneous `css_rise` and `sck_rise`.** `css_rise` wins: the word is discarded.
- **Simultaneous WREN decode and busy expiry.** Cannot occur, because WREN is ignored while `wip`=1.

## Timing
- **Input latency.** 2 `p_clk` of synchronization plus 1 for edge detection. Effects land 3 `p_clk` after the raw SPI edge.
- **SPI clock requirement.**
  - `s_clk` high and low times ≥ 4 `p_clk` each.
  - `s_css` setup to the first `s_clk` rise ≥ 4 `p_clk`.
  - `s_css` hold after the last `s_clk` fall ≥ 4 `p_clk`.
  - `s_mosi` is stable from 1 `p_clk` before the raw rise until 4 `p_clk` after it.
- **READ data placement.** The data for word n is valid on `s_miso` 3 `p_clk` after the raw falling edge that follows the word-0 rise. The controller samples it on the next rising edge. The first falling edge after the command word presents `mem[addr]`.
- **`wip` timing.** `wip` rises 3 `p_clk` after the raw `s_css` rise and stays high for exactly `BUSY_CYCLES` `p_clk`.
- **Memory.** Single-port, one write per `sck_rise`, combinational or registered read. A registered read must still meet the falling-edge slot.

## Test plan
- **Program without WREN.** Frame {addr=0, cmd=0x02} then data 0xFF00FF00 → memory unchanged; `wip`=0; a later READ of addr 0 returns the prior value.
- **WREN then program.** WREN frame → `wel`=1. PROG frame {addr=0, cmd=0x02} with 0xFF00FF00 → after `s_css` rises, `wip`=1 for 16 `p_clk`, then `wip`=`wel`=0. READ addr 0 → `s_miso`=0xFF00FF00 before the second `s_clk` rise.
- **Burst wrap.** WREN, then PROG at addr 255 writing 0x11111111, 0x22222222 → mem[255]=0x11111111, mem[0]=0x22222222. A 2-word READ at addr 255 returns the same pair in order.
- **Busy lockout.** During `wip`=1:
  - RDSR → `s_miso`=0x00000003;
  - READ is ignored and `s_miso` unchanged;
  - after expiry, RDSR → 0x00000000.
- **Abort and reset.**
  - WREN, PROG frame with `s_css` raised before any data word → no write, `wip`=0, `wel`=1.
  - `p_resetn` low mid-READ → `s_miso`=0, `wel`=0; the next full READ frame works normally.
- **Simultaneous `css_rise` and `sck_rise` on a PROG data word** → the word is not written.

Source files
------------

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder: oversamples the SPI link in the p_clk domain, decodes 32-bit
// command words and serves READ/PROGRAM/WREN/WRDI/RDSR from an internal word array.
module spi_flash_responder #(
  parameter int unsigned LINEWIDE    = 32,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned BUSY_CYCLES = 16
) (
  input  logic                p_clk,
  input  logic                p_resetn,
  input  logic                s_clk,
  input  logic                s_css,
  input  logic [LINEWIDE-1:0] s_mosi,
  output logic [LINEWIDE-1:0] s_miso,
  output logic                wip,
  output logic                wel
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(BUSY_CYCLES + 1);

  localparam logic [7:0] CMD_READ = 8'h01;
  localparam logic [7:0] CMD_PROG = 8'h02;
  localparam logic [7:0] CMD_WRDI = 8'h04;
  localparam logic [7:0] CMD_RDSR = 8'h05;
  localparam logic [7:0] CMD_WREN = 8'h06;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_READ,
    ST_PROG,
    ST_RDSR,
    ST_IGNORE
  } state_t;

  logic                sck_meta_q, sck_meta_d, sck_sync_q, sck_sync_d, sck_prev_q, sck_prev_d;
  logic                css_meta_q, css_meta_d, css_sync_q, css_sync_d, css_prev_q, css_prev_d;
  logic [LINEWIDE-1:0] mosi_meta_q, mosi_meta_d, mosi_sync_q, mosi_sync_d;
  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic [LINEWIDE-1:0] miso_q, miso_d;
  logic                wip_q, wip_d;
  logic                wel_q, wel_d;
  logic                wrote_q, wrote_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                mem_we_c;
  logic [7:0]          cmd_c;
  logic                sck_rise_c, sck_fall_c, css_rise_c, css_fall_c;

  logic [LINEWIDE-1:0] mem_q [DEPTH];

  assign sck_rise_c = sck_sync_q & ~sck_prev_q;
  assign sck_fall_c = ~sck_sync_q & sck_prev_q;
  assign css_rise_c = css_sync_q & ~css_prev_q;
  assign css_fall_c = ~css_sync_q & css_prev_q;
  assign cmd_c      = mosi_sync_q[7:0];

  always_comb begin
    sck_meta_d  = s_clk;
    sck_sync_d  = sck_meta_q;
    sck_prev_d  = sck_sync_q;
    css_meta_d  = s_css;
    css_sync_d  = css_meta_q;
    css_prev_d  = css_sync_q;
    mosi_meta_d = s_mosi;
    mosi_sync_d = mosi_meta_q;
    state_d     = state_q;
    idx_d       = idx_q;
    miso_d      = miso_q;
    wip_d       = wip_q;
    wel_d       = wel_q;
    wrote_d     = wrote_q;
    cnt_d       = cnt_q;
    mem_we_c    = 1'b0;

    // Busy countdown; expiry drops both status bits together.
    if (wip_q) begin
      if (cnt_q <= CW'(1)) begin
        wip_d = 1'b0;
        wel_d = 1'b0;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end

    // Chip-select edges outrank any clock edge seen in the same cycle.
    if (css_rise_c) begin
      state_d = ST_IDLE;
      if (state_q == ST_PROG && wrote_q) begin
        wip_d   = 1'b1;
        cnt_d   = CW'(BUSY_CYCLES);
        wrote_d = 1'b0;
      end
    end else if (css_fall_c) begin
      state_d = ST_CMD;
    end else begin
      case (state_q)
        ST_CMD: begin
          if (sck_rise_c) begin
            idx_d = mosi_sync_q[8 +: AW];
            if (wip_q) begin
              state_d = (cmd_c == CMD_RDSR) ? ST_RDSR : ST_IGNORE;
            end else begin
              case (cmd_c)
                CMD_READ: state_d = ST_READ;
                CMD_PROG: state_d = wel_q ? ST_PROG : ST_IGNORE;
                CMD_WREN: begin
                  wel_d   = 1'b1;
                  state_d = ST_IGNORE;
                end
                CMD_WRDI: begin
                  wel_d   = 1'b0;
                  state_d = ST_IGNORE;
                end
                CMD_RDSR: state_d = ST_RDSR;
                default:  state_d = ST_IGNORE;
              endcase
            end
          end
        end
        ST_READ: begin
          if (sck_fall_c) begin
            miso_d = mem_q[idx_q];
            idx_d  = idx_q + AW'(1);
          end
        end
        ST_PROG: begin
          if (sck_rise_c) begin
            mem_we_c = 1'b1;
            idx_d    = idx_q + AW'(1);
            wrote_d  = 1'b1;
          end
        end
        ST_RDSR: begin
          if (sck_fall_c) begin
            miso_d = {(LINEWIDE-2)'(0), wel_q, wip_q};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge p_clk) begin
    if (!p_resetn) begin
      sck_meta_q  <= 1'b0;
      sck_sync_q  <= 1'b0;
      sck_prev_q  <= 1'b0;
      css_meta_q  <= 1'b0;
      css_sync_q  <= 1'b0;
      css_prev_q  <= 1'b0;
      mosi_meta_q <= '0;
      mosi_sync_q <= '0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      miso_q      <= '0;
      wip_q       <= 1'b0;
      wel_q       <= 1'b0;
      wrote_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      sck_meta_q  <= sck_meta_d;
      sck_sync_q  <= sck_sync_d;
      sck_prev_q  <= sck_prev_d;
      css_meta_q  <= css_meta_d;
      css_sync_q  <= css_sync_d;
      css_prev_q  <= css_prev_d;
      mosi_meta_q <= mosi_meta_d;
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      miso_q      <= miso_d;
      wip_q       <= wip_d;
      wel_q       <= wel_d;
      wrote_q     <= wrote_d;
      cnt_q       <= cnt_d;
    end
  end

  // Word array is never reset so contents survive p_resetn.
  always_ff @(posedge p_clk) begin
    if (p_resetn && mem_we_c) begin
      mem_q[idx_q] <= mosi_sync_q;
    end
  end

  assign s_miso = miso_q;
  assign wip    = wip_q;
  assign wel    = wel_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: drives SPI frames, keeps a reference
// memory model and compares sampled responses against a scoreboard queue.
module tb_spi_flash_responder;

  localparam int unsigned BUSY = 16;
  localparam int          PH   = 4;

  logic        p_clk;
  logic        p_resetn;
  logic        s_clk;
  logic        s_css;
  logic [31:0] s_mosi;
  logic [31:0] s_miso;
  logic        wip;
  logic        wel;

  int          checks;
  int          errors;
  logic [31:0] mdl_mem [256];
  logic        mdl_wel;
  logic [31:0] mdl_miso;
  logic [31:0] tx_q [$];
  logic [31:0] rx_q [$];
  logic [31:0] exp_q [$];

  spi_flash_responder #(
    .LINEWIDE   (32),
    .DEPTH      (256),
    .BUSY_CYCLES(BUSY)
  ) dut (
    .p_clk   (p_clk),
    .p_resetn(p_resetn),
    .s_clk   (s_clk),
    .s_css   (s_css),
    .s_mosi  (s_mosi),
    .s_miso  (s_miso),
    .wip     (wip),
    .wel     (wel)
  );

  initial p_clk = 1'b0;
  always #5 p_clk = ~p_clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge p_clk);
  endtask

  // Sends every queued word as one frame; samples s_miso late in each low phase.
  task automatic spi_frame();
    s_css = 1'b0;
    while (tx_q.size() > 0) begin
      s_mosi = tx_q.pop_front();
      cyc(PH);
      s_clk = 1'b1;
      cyc(PH);
      s_clk = 1'b0;
      cyc(PH);
      rx_q.push_back(s_miso);
    end
    s_css = 1'b1;
  endtask

  task automatic cmd_word(input logic [7:0] cmd, input logic [23:0] addr);
    tx_q.push_back({addr, cmd});
  endtask

  task automatic do_wren();
    cmd_word(8'h06, 24'd0);
    spi_frame();
    cyc(PH);
    rx_q.delete();
    mdl_wel = 1'b1;
  endtask

  task automatic read_frame(input logic [23:0] addr, input int n);
    logic [7:0] a;
    a = addr[7:0];
    cmd_word(8'h01, addr);
    for (int i = 1; i < n; i++) tx_q.push_back(32'h0);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(mdl_mem[a]);
      mdl_miso = mdl_mem[a];
      a = a + 8'd1;
    end
    rx_q.delete();
    spi_frame();
    cyc(PH);
  endtask

  task automatic test_reset();
    p_resetn = 1'b0;
    cyc(3);
    p_resetn = 1'b1;
    cyc(4);
    checks++;
    if (s_miso !== 32'h0) begin errors++; $display("FAIL reset_miso: got %h expected %h", s_miso, 32'h0); end
    checks++;
    if (wip !== 1'b0) begin errors++; $display("FAIL reset_wip: got %b expected 0", wip); end
    checks++;
    if (wel !== 1'b0) begin errors++; $display("FAIL reset_wel: got %b expected 0", wel); end
  endtask

  task automatic test_wren_program();
    int lat;
    int hi;
    logic [31:0] got, exp_v;
    do_wren();
    checks++;
    if (wel !== 1'b1) begin errors++; $display("FAIL wren_wel: got %b expected 1", wel); end
    cmd_word(8'h02, 24'd0);
    tx_q.push_back(32'hFF00FF00);
    spi_frame();
    rx_q.delete();
    lat = 0;
    while (wip !== 1'b1 && lat < 20) begin cyc(1); lat++; end
    checks++;
    if (lat != 3) begin errors++; $display("FAIL wip_latency: got %0d cycles expected 3", lat); end
    hi = 0;
    while (wip === 1'b1 && hi < 100) begin hi++; cyc(1); end
    checks++;
    if (hi != int'(BUSY)) begin errors++; $display("FAIL wip_duration: got %0d cycles expected %0d", hi, BUSY); end
    checks++;
    if (wel !== 1'b0) begin errors++; $display("FAIL wel_after_busy: got %b expected 0", wel); end
    mdl_mem[0] = 32'hFF00FF00;
    mdl_wel = 1'b0;
    cyc(PH);
    read_frame(24'd0, 1);
    got = rx_q.pop_front();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL read_after_prog: got %h expected %h", got, exp_v); end
  endtask

  task automatic test_prog_no_wren();
    logic [31:0] got, exp_v;
    cmd_word(8'h02, 24'd0);
    tx_q.push_back(32'h12345678);
    spi_frame();
    rx_q.delete();
    cyc(6);
    checks++;
    if (wip !== 1'b0) begin errors++; $display("FAIL nowren_wip: got %b expected 0", wip); end
    cyc(PH);
    read_frame(24'd0, 1);
    got = rx_q.pop_front();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL nowren_read: got %h expected %h", got, exp_v); end
  endtask

  task automatic test_burst_wrap();
    logic [31:0] got, exp_v;
    do_wren();
    cmd_word(8'h02, 24'd255);
    tx_q.push_back(32'h11111111);
    tx_q.push_back(32'h22222222);
    spi_frame();
    rx_q.delete();
    cyc(BUSY + 10);
    mdl_mem[255] = 32'h11111111;
    mdl_mem[0]   = 32'h22222222;
    mdl_wel      = 1'b0;
    checks++;
    if (wel !== mdl_wel) begin errors++; $display("FAIL burst_wel: got %b expected %b", wel, mdl_wel); end
    read_frame(24'd255, 2);
    for (int i = 0; i < 2; i++) begin
      got = rx_q.pop_front();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL burst_read_%0d: got %h expected %h", i, got, exp_v); end
    end
  endtask

  task automatic test_busy_lockout();
    logic [31:0] got, exp_v;
    // READ issued while busy must leave s_miso alone.
    do_wren();
    cmd_word(8'h02, 24'd10);
    tx_q.push_back(32'hDEADBEEF);
    spi_frame();
    rx_q.delete();
    cyc(2);
    cmd_word(8'h01, 24'd0);
    exp_q.push_back(mdl_miso);
    spi_frame();
    cyc(BUSY + 10);
    got = rx_q.pop_front();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL busy_read_ignored: got %h expected %h", got, exp_v); end
    mdl_mem[10] = 32'hDEADBEEF;
    mdl_wel = 1'b0;
    // RDSR while busy reports both bits.
    do_wren();
    cmd_word(8'h02, 24'd11);
    tx_q.push_back(32'h0BADF00D);
    spi_frame();
    rx_q.delete();
    cyc(2);
    cmd_word(8'h05, 24'd0);
    exp_q.push_back(32'h00000003);
    spi_frame();
    cyc(BUSY + 10);
    got = rx_q.pop_front();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL busy_rdsr: got %h expected %h", got, exp_v); end
    mdl_mem[11] = 32'h0BADF00D;
    mdl_wel = 1'b0;
    cmd_word(8'h05, 24'd0);
    exp_q.push_back(32'h00000000);
    spi_frame();
    cyc(PH);
    mdl_miso = 32'h0;
    got = rx_q.pop_front();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL idle_rdsr: got %h expected %h", got, exp_v); end
    read_frame(24'd10, 2);
    for (int i = 0; i < 2; i++) begin
      got = rx_q.pop_front();
      exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL busy_written_%0d: got %h expected %h", i, got, exp_v); end
    end
  endtask

  task automatic test_abort_reset();
    logic [31:0] got, exp_v;
    do_wren();
    cmd_word(8'h02, 24'd20);
    spi_frame();
    rx_q.delete();
    cyc(10);
    checks++;
    if (wip !== 1'b0) begin errors++; $display("FAIL abort_wip: got %b expected 0", wip); end
    checks++;
    if (wel !== mdl_wel) begin errors++; $display("FAIL abort_wel: got %b expected %b", wel, mdl_wel); end
    // Start a READ, then reset after the first data word is presented.
    exp_q.push_back(mdl_mem[10]);
    s_css = 1'b0;
    s_mosi = {24'd10, 8'h01};
    cyc(PH);
    s_clk = 1'b1;
    cyc(PH);
    s_clk = 1'b0;
    cyc(PH);
    got = s_miso;
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL midread_data: got %h expected %h", got, exp_v); end
    p_resetn = 1'b0;
    s_css = 1'b1;
    cyc(2);
    p_resetn = 1'b1;
    cyc(1);
    mdl_wel = 1'b0;
    mdl_miso = 32'h0;
    checks++;
    if (s_miso !== mdl_miso) begin errors++; $display("FAIL midreset_miso: got %h expected %h", s_miso, mdl_miso); end
    checks++;
    if (wel !== mdl_wel) begin errors++; $display("FAIL midreset_wel: got %b expected %b", wel, mdl_wel); end
    cyc(PH);
    read_frame(24'd11, 1);
    got = rx_q.pop_front();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL read_after_reset: got %h expected %h", got, exp_v); end
  endtask

  task automatic test_css_sck_collision();
    logic [31:0] got, exp_v;
    do_wren();
    s_css = 1'b0;
    s_mosi = {24'd0, 8'h02};
    cyc(PH);
    s_clk = 1'b1;
    cyc(PH);
    s_clk = 1'b0;
    s_mosi = 32'h5555AAAA;
    cyc(PH);
    s_clk = 1'b1;
    s_css = 1'b1;
    cyc(PH);
    s_clk = 1'b0;
    cyc(10);
    checks++;
    if (wip !== 1'b0) begin errors++; $display("FAIL collide_wip: got %b expected 0", wip); end
    checks++;
    if (wel !== mdl_wel) begin errors++; $display("FAIL collide_wel: got %b expected %b", wel, mdl_wel); end
    read_frame(24'd0, 1);
    got = rx_q.pop_front();
    exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin errors++; $display("FAIL collide_read: got %h expected %h", got, exp_v); end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    p_resetn = 1'b0;
    s_clk    = 1'b0;
    s_css    = 1'b1;
    s_mosi   = 32'h0;
    mdl_wel  = 1'b0;
    mdl_miso = 32'h0;
    cyc(3);
    test_reset();
    test_wren_program();
    test_prog_no_wren();
    test_burst_wrap();
    test_busy_lockout();
    test_abort_reset();
    test_css_sck_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
